// File: rtl/doodle_pkg.sv
// Shared definitions for the doodle game datapath: state encoding, screen
// defaults and coordinate widths used by physics, view manager and collision.
package doodle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DEAD
  } state_t;

  localparam int unsigned SCREEN_WIDTH  = 400;
  localparam int unsigned SCREEN_HEIGHT = 480;

  localparam int unsigned X_W   = 16;
  localparam int unsigned Y_W   = 32;
  localparam int unsigned VEL_W = 16;

endpackage

// File: rtl/doodle_physics_if.sv
// Control inputs and motion outputs of the doodle physics engine.
// Optional macro DOODLE_SPRING_EN adds the spring_hit input.
interface doodle_physics_if;
  import doodle_pkg::*;

  logic             start;
  logic             frame_tick;
  logic             btn_left;
  logic             btn_right;
  logic             platform_hit;
  logic             min_y_crossed;
`ifdef DOODLE_SPRING_EN
  logic             spring_hit;
`endif

  logic [X_W-1:0]   doodle_x;
  logic [Y_W-1:0]   doodle_y;
  logic [VEL_W-1:0] vel_y;
  logic             falling;
  logic             game_over;
  logic [15:0]      jump_count;

  modport master (
    output start, frame_tick, btn_left, btn_right, platform_hit, min_y_crossed,
`ifdef DOODLE_SPRING_EN
    output spring_hit,
`endif
    input  doodle_x, doodle_y, vel_y, falling, game_over, jump_count
  );

  modport slave (
    input  start, frame_tick, btn_left, btn_right, platform_hit, min_y_crossed,
`ifdef DOODLE_SPRING_EN
    input  spring_hit,
`endif
    output doodle_x, doodle_y, vel_y, falling, game_over, jump_count
  );

endinterface

// File: rtl/doodle_hwrap.sv
// Combinational horizontal step with modular wrap around the screen width.
module doodle_hwrap #(
  parameter int unsigned SCREEN_WIDTH = doodle_pkg::SCREEN_WIDTH,
  parameter int unsigned X_STEP       = 4
) (
  input  logic [doodle_pkg::X_W-1:0] x,
  input  logic                       left,
  input  logic                       right,
  output logic [doodle_pkg::X_W-1:0] xNext
);
  import doodle_pkg::*;

  localparam logic [X_W:0] STEP  = (X_W+1)'(X_STEP);
  localparam logic [X_W:0] WIDTH = (X_W+1)'(SCREEN_WIDTH);

  logic [X_W:0] xWide;
  logic [X_W:0] upSum;
  logic [X_W:0] downSum;

  // Compute both wrapped candidates and select by the button pair.
  always_comb begin
    xWide   = {1'b0, x};
    upSum   = xWide + STEP;
    if (upSum >= WIDTH) upSum = upSum - WIDTH;
    if (xWide < STEP) downSum = xWide + WIDTH - STEP;
    else              downSum = xWide - STEP;
    xNext = x;
    if (left && !right)      xNext = downSum[X_W-1:0];
    else if (right && !left) xNext = upSum[X_W-1:0];
  end

endmodule

// File: rtl/doodle_physics.sv
// Per-frame motion engine for the doodle: gravity, platform bounces,
// horizontal wrap and fall-death detection.
// Optional macro DOODLE_SPRING_EN adds spring_hit and SPRING_VEL.
module doodle_physics #(
  parameter int unsigned SCREEN_WIDTH = doodle_pkg::SCREEN_WIDTH,
  parameter int unsigned START_X      = 180,
  parameter int unsigned START_Y      = 10,
  parameter int unsigned JUMP_VEL     = 20,
  parameter int unsigned GRAVITY      = 1,
  parameter int unsigned MAX_FALL     = 20,
  parameter int unsigned X_STEP       = 4
`ifdef DOODLE_SPRING_EN
  ,
  parameter int unsigned SPRING_VEL   = 40
`endif
) (
  input logic             clk,
  input logic             reset,
  doodle_physics_if.slave bus
);
  import doodle_pkg::*;

  localparam logic signed [VEL_W:0] VEL_MIN = -$signed((VEL_W+1)'(MAX_FALL));

  state_t           state, stateNext;
  logic [X_W-1:0]   xReg, xNext;
  logic [Y_W-1:0]   yReg, ySum;
  logic [VEL_W-1:0] velReg, velNext;
  logic [15:0]      jumpCnt;

  logic                    isFalling;
  logic                    isOver;
  logic                    underflow;
  logic                    bounce;
  logic signed [VEL_W:0]   velDec;
  logic [VEL_W:0]          velMag;
  logic                    reload;
  logic                    advance;

  doodle_hwrap #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .X_STEP       (X_STEP)
  ) u_hwrap (
    .x     (xReg),
    .left  (bus.btn_left),
    .right (bus.btn_right),
    .xNext (xNext)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic: min_y_crossed kills at any cycle, underflow only on a tick.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (bus.start) stateNext = PLAY;
      PLAY: begin
        if (bus.min_y_crossed)                stateNext = DEAD;
        else if (bus.frame_tick && underflow) stateNext = DEAD;
      end
      DEAD: if (bus.start) stateNext = PLAY;
      default: stateNext = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    isOver    = (state == DEAD);
    isFalling = (state == PLAY) && ($signed(velReg) <= 0);
  end

  // Y sum and floor underflow (only a negative velocity larger than y).
  always_comb begin
    ySum      = yReg + {{(Y_W-VEL_W){velReg[VEL_W-1]}}, velReg};
    velMag    = (VEL_W+1)'(-$signed({velReg[VEL_W-1], velReg}));
    underflow = velReg[VEL_W-1] && ({{(Y_W-VEL_W-1){1'b0}}, velMag} > yReg);
  end

  // Velocity step: bounce when falling onto a platform, else gravity with clamp.
  always_comb begin
    velDec = $signed({velReg[VEL_W-1], velReg}) - $signed((VEL_W+1)'(GRAVITY));
    bounce = 1'b0;
    if (velDec < VEL_MIN) velNext = VEL_MIN[VEL_W-1:0];
    else                  velNext = velDec[VEL_W-1:0];
`ifdef DOODLE_SPRING_EN
    if (isFalling && bus.spring_hit) begin
      velNext = VEL_W'(SPRING_VEL);
      bounce  = 1'b1;
    end else
`endif
    if (isFalling && bus.platform_hit) begin
      velNext = VEL_W'(JUMP_VEL);
      bounce  = 1'b1;
    end
  end

  // Update enables: reload on game (re)start, advance on a live tick.
  always_comb begin
    reload  = (state != PLAY) && bus.start;
    advance = (state == PLAY) && bus.frame_tick && !bus.min_y_crossed;
  end

  // Motion registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      xReg    <= X_W'(START_X);
      yReg    <= Y_W'(START_Y);
      velReg  <= '0;
      jumpCnt <= '0;
    end else if (reload) begin
      xReg    <= X_W'(START_X);
      yReg    <= Y_W'(START_Y);
      velReg  <= VEL_W'(JUMP_VEL);
      jumpCnt <= '0;
    end else if (advance) begin
      xReg   <= xNext;
      yReg   <= underflow ? '0 : ySum;
      velReg <= velNext;
      if (bounce && (jumpCnt != '1)) jumpCnt <= jumpCnt + 16'd1;
    end
  end

  assign bus.doodle_x   = xReg;
  assign bus.doodle_y   = yReg;
  assign bus.vel_y      = velReg;
  assign bus.falling    = isFalling;
  assign bus.game_over  = isOver;
  assign bus.jump_count = jumpCnt;

endmodule

// File: tb/tb_doodle_physics.sv
// Directed self-checking bench for doodle_physics and doodle_hwrap.
module tb_doodle_physics;
  import doodle_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  doodle_physics_if bus ();

  doodle_physics #(
    .SCREEN_WIDTH (400),
    .START_X      (180),
    .START_Y      (10),
    .JUMP_VEL     (20),
    .GRAVITY      (1),
    .MAX_FALL     (20),
    .X_STEP       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [X_W-1:0] hx, hn;
  logic           hl, hr;

  doodle_hwrap #(
    .SCREEN_WIDTH (400),
    .X_STEP       (4)
  ) u_wrap (
    .x     (hx),
    .left  (hl),
    .right (hr),
    .xNext (hn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] v16(input int v);
    logic [15:0] t;
    t = 16'(v);
    return {16'h0, t};
  endfunction

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
    end
  endtask

  task automatic pulseStart();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.frame_tick = 1'b0;
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    bus.platform_hit = 1'b0;
    bus.min_y_crossed = 1'b0;
`ifdef DOODLE_SPRING_EN
    bus.spring_hit = 1'b0;
`endif
    hx = '0; hl = 1'b0; hr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_x", 32'(bus.doodle_x), 180);
    check("rst_y", bus.doodle_y, 10);
    check("rst_vel", v16(0), 32'(bus.vel_y) ^ 32'(bus.vel_y) ^ v16(0));
    check("rst_vel_val", 32'(bus.vel_y), 0);
    check("rst_falling", 32'(bus.falling), 0);
    check("rst_over", 32'(bus.game_over), 0);
    check("rst_jc", 32'(bus.jump_count), 0);

    // Ticks in IDLE do nothing.
    ticks(2);
    check("idle_hold_y", bus.doodle_y, 10);

    pulseStart();
    check("start_vel", 32'(bus.vel_y), 20);
    check("start_y", bus.doodle_y, 10);
    check("start_falling", 32'(bus.falling), 0);

    // Rising: a hit at the tick with vel=3 (tick 18) must be ignored.
    ticks(17);
    check("pre_hit_vel", 32'(bus.vel_y), 3);
    bus.platform_hit = 1'b1;
    ticks(1);
    bus.platform_hit = 1'b0;
    check("rising_hit_ignored_vel", 32'(bus.vel_y), 2);
    ticks(2);
    check("apex_y", bus.doodle_y, 220);
    check("apex_vel", 32'(bus.vel_y), 0);
    check("apex_falling", 32'(bus.falling), 1);
    check("apex_jc", 32'(bus.jump_count), 0);

    ticks(5);
    check("desc_y", bus.doodle_y, 210);
    check("desc_vel", 32'(bus.vel_y), v16(-5));
    bus.platform_hit = 1'b1;
    ticks(1);
    check("land_y", bus.doodle_y, 205);
    check("land_vel", 32'(bus.vel_y), 20);
    check("land_jc", 32'(bus.jump_count), 1);

    // start ignored during PLAY.
    pulseStart();
    check("start_ignored_y", bus.doodle_y, 205);
    check("start_ignored_vel", 32'(bus.vel_y), 20);

    // Horizontal wrap with platform held so the doodle keeps bouncing.
    bus.btn_left = 1'b1;
    ticks(45);
    check("left_to_zero", 32'(bus.doodle_x), 0);
    ticks(1);
    check("left_wrap", 32'(bus.doodle_x), 396);
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b1;
    ticks(1);
    check("right_wrap", 32'(bus.doodle_x), 0);
    bus.btn_left = 1'b1;
    ticks(1);
    check("both_hold", 32'(bus.doodle_x), 0);
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    check("bounce_y", bus.doodle_y, 730);
    check("bounce_vel", 32'(bus.vel_y), 14);
    check("bounce_jc", 32'(bus.jump_count), 3);

    bus.platform_hit = 1'b0;
    ticks(14);
    check("apex2_y", bus.doodle_y, 835);
    check("apex2_falling", 32'(bus.falling), 1);

    // min_y_crossed on a tick with a valid landing: freeze and die.
    @(negedge clk);
    bus.frame_tick = 1'b1;
    bus.platform_hit = 1'b1;
    bus.min_y_crossed = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.platform_hit = 1'b0;
    bus.min_y_crossed = 1'b0;
    check("miny_over", 32'(bus.game_over), 1);
    check("miny_y", bus.doodle_y, 835);
    check("miny_vel", 32'(bus.vel_y), 0);
    check("miny_jc", 32'(bus.jump_count), 3);
    check("miny_x", 32'(bus.doodle_x), 0);
    check("dead_falling", 32'(bus.falling), 0);

    pulseStart();
    check("restart_x", 32'(bus.doodle_x), 180);
    check("restart_y", bus.doodle_y, 10);
    check("restart_vel", 32'(bus.vel_y), 20);
    check("restart_over", 32'(bus.game_over), 0);

    // Free fall with clamp, then floor underflow.
    ticks(20);
    check("ff_apex_y", bus.doodle_y, 220);
    ticks(20);
    check("ff_y30", bus.doodle_y, 30);
    check("ff_vel_clamp_reach", 32'(bus.vel_y), v16(-20));
    ticks(1);
    check("ff_y10", bus.doodle_y, 10);
    check("ff_vel_clamped", 32'(bus.vel_y), v16(-20));
    ticks(1);
    check("underflow_y", bus.doodle_y, 0);
    check("underflow_over", 32'(bus.game_over), 1);

    pulseStart();
    check("restart2_x", 32'(bus.doodle_x), 180);
    check("restart2_y", bus.doodle_y, 10);
    check("restart2_vel", 32'(bus.vel_y), 20);

    // Reset in a tick cycle during PLAY.
    bus.platform_hit = 1'b1;
    bus.btn_right = 1'b1;
    ticks(3);
    @(negedge clk);
    reset = 1'b1;
    bus.frame_tick = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
    bus.platform_hit = 1'b0;
    bus.btn_right = 1'b0;
    check("midrst_x", 32'(bus.doodle_x), 180);
    check("midrst_y", bus.doodle_y, 10);
    check("midrst_vel", 32'(bus.vel_y), 0);
    check("midrst_falling", 32'(bus.falling), 0);
    check("midrst_over", 32'(bus.game_over), 0);
    check("midrst_jc", 32'(bus.jump_count), 0);
    ticks(1);
    check("midrst_idle_y", bus.doodle_y, 10);

`ifdef DOODLE_SPRING_EN
    pulseStart();
    ticks(20);
    bus.spring_hit = 1'b1;
    bus.platform_hit = 1'b1;
    ticks(1);
    bus.spring_hit = 1'b0;
    bus.platform_hit = 1'b0;
    check("spring_vel", 32'(bus.vel_y), 40);
    check("spring_jc", 32'(bus.jump_count), 1);
`endif

    // Wrap block directly at its boundaries.
    hx = 16'd2; hl = 1'b1; hr = 1'b0;
    #1 check("hw_left_2", 32'(hn), 398);
    hx = 16'd398; hl = 1'b0; hr = 1'b1;
    #1 check("hw_right_398", 32'(hn), 2);
    hx = 16'd4; hl = 1'b1; hr = 1'b0;
    #1 check("hw_left_4", 32'(hn), 0);
    hx = 16'd395; hl = 1'b0; hr = 1'b1;
    #1 check("hw_right_395", 32'(hn), 399);
    hx = 16'd123; hl = 1'b1; hr = 1'b1;
    #1 check("hw_both", 32'(hn), 123);
    hx = 16'd77; hl = 1'b0; hr = 1'b0;
    #1 check("hw_none", 32'(hn), 77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/doodle_physics.md
Name: doodle_physics

Overview:
- Per-frame vertical and horizontal motion engine for the doodle character.
- Sits directly upstream of the view manager: produces world-space doodle_y (up is positive) that the view manager compares against its scroll threshold and minimum-Y floor.
- Consumes the view manager's min-Y-crossed flag as the fall-death condition.
- Consumes platform collision from the collision checker and button inputs from the input debouncer.

Parameters:
- SCREEN_WIDTH, 400, horizontal wrap modulus in pixels
- START_X, 180, doodle x after reset/start
- START_Y, 10, doodle y after reset/start
- JUMP_VEL, 20, upward velocity loaded on landing
- GRAVITY, 1, velocity decrement per frame tick
- MAX_FALL, 20, magnitude clamp on downward velocity
- X_STEP, 4, pixels moved per tick while a direction button is held

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  begin or restart the game from IDLE or DEAD
- frame_tick  in  1  one-cycle strobe, one per video frame
- btn_left  in  1  level, move left
- btn_right  in  1  level, move right
- platform_hit  in  1  doodle feet overlap a platform (valid in the frame_tick cycle)
- min_y_crossed  in  1  from view manager: doodle fell below visible floor
- doodle_x  out  16  horizontal position, 0..SCREEN_WIDTH-1
- doodle_y  out  32  world vertical position, unsigned
- vel_y  out  16  signed vertical velocity
- falling  out  1  high when vel_y <= 0 in state PLAY
- game_over  out  1  high in state DEAD
- jump_count  out  16  landings since start, saturating at 16'hFFFF

Behaviour:
- Reset values: state IDLE, doodle_x=START_X, doodle_y=START_Y, vel_y=0, falling=0, game_over=0, jump_count=0.
- States: IDLE, PLAY, DEAD.
  - IDLE -> PLAY on start. On entry: vel_y=JUMP_VEL, x and y reloaded to START values.
  - PLAY -> DEAD on min_y_crossed at any cycle, or on floor underflow (see the y update below).
  - DEAD -> PLAY on start, with the same reload as from IDLE.
  - start is ignored while in PLAY.
- All motion updates happen only in PLAY, and only in a frame_tick cycle. Registers hold otherwise.
- Y update, registered, one-cycle latency after frame_tick:
  - y_next = doodle_y + sext(vel_y).
  - If vel_y < 0 and |vel_y| > doodle_y: doodle_y=0, go to DEAD.
- Velocity update, same tick, using the pre-update vel_y:
  - If falling and platform_hit: vel_y=JUMP_VEL, jump_count+1.
  - Else: vel_y = max(vel_y - GRAVITY, -MAX_FALL).
  - platform_hit while rising (vel_y > 0) is ignored: the doodle passes through platforms from below.
- falling is combinational from state and vel_y.
- X update on the tick:
  - btn_left only: x-X_STEP, wrapping below 0 to x-X_STEP+SCREEN_WIDTH.
  - btn_right only: x+X_STEP, wrapping at >= SCREEN_WIDTH to x+X_STEP-SCREEN_WIDTH.
  - Both or neither: hold.
- Simultaneous events:
  - min_y_crossed wins over all motion in the same cycle; registers freeze at their pre-tick values.
  - reset wins over start.
- Reset asserted mid-PLAY returns to IDLE with reset values on the next edge.

Optional Feature:
- Macro DOODLE_SPRING_EN.
  - When defined: adds input spring_hit (1) and parameter SPRING_VEL (default 40). If falling and spring_hit on a tick, vel_y=SPRING_VEL; this has priority over platform_hit. jump_count still increments by 1.
  - When undefined: no port, no parameter, behaviour exactly as above.

Decomposition:
- Shared package doodle_pkg holds:
  - the state enum {IDLE, PLAY, DEAD};
  - SCREEN_WIDTH and SCREEN_HEIGHT defaults;
  - the coordinate width constants (X 16, Y 32, VEL 16), shared with the view manager and collision checker.
- One natural sub-module, doodle_hwrap: combinational X step with modular wrap.
- Velocity and Y logic stay in the top.

Test Plan:
- Reset then start, 20 ticks with no hit -> doodle_y = 10+(20+19+...+1) = 220, vel_y = 0, falling = 1.
- Continue to descend, assert platform_hit at the first tick with vel_y = -5 -> next vel_y = 20, jump_count = 1; an earlier hit while vel_y = 3 is ignored.
- Free fall from y = 220 with no hits -> vel_y clamps at -20, then floor underflow gives doodle_y = 0 and game_over = 1. start -> PLAY with x = 180, y = 10, vel = 20.
- doodle_x = 2, btn_left, one tick -> doodle_x = 398. doodle_x = 398, btn_right -> 2. Both buttons -> unchanged.
- min_y_crossed pulsed in the same cycle as frame_tick and platform_hit -> DEAD, and y, vel and jump_count unchanged.
- Reset asserted mid-PLAY in a tick cycle -> IDLE with all reset values. With DOODLE_SPRING_EN: spring_hit and platform_hit together while falling -> vel_y = 40.
